uart_trans: RTL and testbench

- 8N1 UART transmitter, the outbound counterpart of the team's UART receiver (uart_rec) on the same link.
- Sends 1 start bit (low), 8 data bits LSB first, and 1 stop bit (high). Each bit lasts exactly PERIOD clk cycles.
- A small internal byte FIFO lets upstream logic (command/echo path, VGA status reporting) queue several bytes without waiting for each frame.

---
 rtl/uart_trans.sv | 142 ++++++++++++++
 tb/tb_uart_trans.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_trans.sv
// 8N1 UART transmitter with an internal byte FIFO.
// Line outputs are registered from the FSM state, so they trail the state by one cycle.
module uart_trans #(
  parameter int unsigned PERIOD = 10417,
  parameter int unsigned DEPTH  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       wr_en,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       busy,
  output logic       serial_out
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(PERIOD);

  typedef enum logic [1:0] {s_IDLE, s_START, s_DATA, s_STOP} state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, ovf_q;

  state_t        state_q;
  logic [TW-1:0] tick_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          serial_q, busy_q;

  logic push, pop, last_tick;

  always_comb begin
    last_tick = (tick_q == TW'(PERIOD - 1));
    push      = wr_en && !full_q;
    pop       = !empty_q && ((state_q == s_IDLE) || (state_q == s_STOP && last_tick));
    count_d   = count_q;
    if (push && !pop)
      count_d = count_q + CW'(1);
    else if (!push && pop)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wptr_q] <= data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (push)
        wptr_q <= wptr_q + PW'(1);
      if (pop)
        rptr_q <= rptr_q + PW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
      ovf_q   <= wr_en && full_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= s_IDLE;
      tick_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        s_START: serial_q <= 1'b0;
        s_DATA:  serial_q <= shift_q[0];
        default: serial_q <= 1'b1;
      endcase
      busy_q <= (state_q != s_IDLE);

      case (state_q)
        s_IDLE: begin
          tick_q <= '0;
          idx_q  <= '0;
          if (pop) begin
            shift_q <= mem_q[rptr_q];
            state_q <= s_START;
          end
        end
        s_START: begin
          if (last_tick) begin
            tick_q  <= '0;
            idx_q   <= '0;
            state_q <= s_DATA;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        s_DATA: begin
          if (last_tick) begin
            tick_q  <= '0;
            shift_q <= shift_q >> 1;
            if (idx_q == 3'd7)
              state_q <= s_STOP;
            else
              idx_q <= idx_q + 3'd1;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        default: begin
          if (last_tick) begin
            tick_q <= '0;
            if (pop) begin
              shift_q <= mem_q[rptr_q];
              state_q <= s_START;
            end else begin
              state_q <= s_IDLE;
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
      endcase
    end
  end

  assign full       = full_q;
  assign empty      = empty_q;
  assign overflow   = ovf_q;
  assign busy       = busy_q;
  assign serial_out = serial_q;

endmodule

// File: tb/tb_uart_trans.sv
// Directed self-checking bench for uart_trans with PERIOD=16, DEPTH=4.
module tb_uart_trans;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       wr_en;
  logic       full, empty, overflow, busy, serial_out;

  int nchk = 0;
  int nerr = 0;

  uart_trans #(.PERIOD(16), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .wr_en      (wr_en),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .busy       (busy),
    .serial_out (serial_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks every line cycle of a frame from cycle 'first' through cycle 159,
  // optionally issuing one write after the sample of cycle 'wr_at'.
  task automatic check_frame(input logic [7:0] b, input int first, input int wr_at,
                             input logic [7:0] wd, output logic e_before, output logic e_last);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    e_before = 1'bx;
    e_last   = 1'bx;
    for (int i = first; i < 160; i++) begin
      if (i > first) begin
        step();
        wr_en = 1'b0;
      end
      chk($sformatf("ser_%0h_c%0d", b, i), {31'd0, serial_out}, {31'd0, fr[i / 16]});
      chk($sformatf("busy_%0h_c%0d", b, i), {31'd0, busy}, 32'd1);
      if (i == 158) e_before = empty;
      if (i == 159) e_last = empty;
      if (i == wr_at) begin
        wr_en = 1'b1;
        data  = wd;
      end
    end
    wr_en = 1'b0;
  endtask

  initial begin
    logic eb, el;
    int   bad;

    rst = 1'b1; wr_en = 1'b0; data = 8'h00;
    step();
    step();
    chk("rst_serial", {31'd0, serial_out}, 32'd1);
    chk("rst_busy",   {31'd0, busy},       32'd0);
    chk("rst_full",   {31'd0, full},       32'd0);
    chk("rst_empty",  {31'd0, empty},      32'd1);
    chk("rst_ovf",    {31'd0, overflow},   32'd0);
    rst = 1'b0;
    step();
    step();

    // Single byte 0xA5
    wr_en = 1'b1; data = 8'hA5;
    step();
    wr_en = 1'b0;
    chk("a5_empty_n",  {31'd0, empty},      32'd0);
    chk("a5_ser_n",    {31'd0, serial_out}, 32'd1);
    step();
    chk("a5_empty_n1", {31'd0, empty},      32'd1);
    chk("a5_ser_n1",   {31'd0, serial_out}, 32'd1);
    chk("a5_busy_n1",  {31'd0, busy},       32'd0);
    step();
    check_frame(8'hA5, 0, -1, 8'h00, eb, el);
    step();
    chk("a5_busy_end", {31'd0, busy},       32'd0);
    chk("a5_ser_end",  {31'd0, serial_out}, 32'd1);
    step();

    // Burst 0x00, 0xFF, 0x55
    wr_en = 1'b1; data = 8'h00;
    step();
    data = 8'hFF;
    step();
    data = 8'h55;
    step();
    wr_en = 1'b0;
    check_frame(8'h00, 0, -1, 8'h00, eb, el);
    chk("burst_empty_f0", {31'd0, el}, 32'd0);
    step();
    check_frame(8'hFF, 0, -1, 8'h00, eb, el);
    chk("burst_empty_pre55", {31'd0, eb}, 32'd0);
    chk("burst_empty_pop55", {31'd0, el}, 32'd1);
    step();
    check_frame(8'h55, 0, -1, 8'h00, eb, el);
    step();
    chk("burst_busy_end", {31'd0, busy}, 32'd0);
    step();

    // Fill and overflow
    wr_en = 1'b1; data = 8'h11;
    step();
    data = 8'h22;
    step();
    data = 8'h33;
    step();
    chk("fill_ser_n2", {31'd0, serial_out}, 32'd0);
    data = 8'h44;
    step();
    chk("fill_full_n3", {31'd0, full}, 32'd0);
    data = 8'h55;
    step();
    chk("fill_full_n4", {31'd0, full},     32'd1);
    chk("fill_ovf_n4",  {31'd0, overflow}, 32'd0);
    data = 8'h66;
    step();
    chk("fill_ovf_n5",  {31'd0, overflow}, 32'd1);
    chk("fill_full_n5", {31'd0, full},     32'd1);
    wr_en = 1'b0;
    step();
    chk("fill_ovf_n6",  {31'd0, overflow}, 32'd0);
    chk("fill_full_n6", {31'd0, full},     32'd1);
    check_frame(8'h11, 4, -1, 8'h00, eb, el);
    for (int k = 2; k <= 5; k++) begin
      step();
      check_frame(8'(k * 17), 0, -1, 8'h00, eb, el);
    end
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (serial_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("fill_no_6th_frame", bad, 0);

    // Pointer wrap: 0x01..0x0A
    wr_en = 1'b1; data = 8'h01;
    step();
    wr_en = 1'b0;
    step();
    step();
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) step();
      check_frame(8'(k), 0, (k < 10) ? 80 : -1, 8'(k + 1), eb, el);
    end
    step();
    chk("wrap_busy_end",  {31'd0, busy},  32'd0);
    chk("wrap_empty_end", {31'd0, empty}, 32'd1);
    step();

    // Reset during data bit 3 with two bytes queued
    wr_en = 1'b1; data = 8'hA1;
    step();
    data = 8'hB2;
    step();
    data = 8'hC3;
    step();
    wr_en = 1'b0;
    chk("mid_ser_start", {31'd0, serial_out}, 32'd0);
    for (int i = 0; i < 70; i++) step();
    chk("mid_queued", {31'd0, empty}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ser",   {31'd0, serial_out}, 32'd1);
    chk("mid_rst_busy",  {31'd0, busy},       32'd0);
    chk("mid_rst_empty", {31'd0, empty},      32'd1);
    chk("mid_rst_full",  {31'd0, full},       32'd0);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (serial_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("mid_no_frames", bad, 0);

    // Write on the same edge as the final STOP pop
    wr_en = 1'b1; data = 8'h81;
    step();
    data = 8'h42;
    step();
    wr_en = 1'b0;
    step();
    check_frame(8'h81, 0, 158, 8'h3C, eb, el);
    chk("wdp_empty_pre", {31'd0, eb}, 32'd0);
    chk("wdp_empty_pop", {31'd0, el}, 32'd0);
    step();
    check_frame(8'h42, 0, -1, 8'h00, eb, el);
    chk("wdp_empty_pop3c", {31'd0, el}, 32'd1);
    step();
    check_frame(8'h3C, 0, -1, 8'h00, eb, el);
    step();
    chk("wdp_busy_end",  {31'd0, busy},       32'd0);
    chk("wdp_ser_end",   {31'd0, serial_out}, 32'd1);
    chk("wdp_empty_end", {31'd0, empty},      32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
